trap_handler_ctrl: RTL

- Responder side of the decode-stage trap interface. Consumes DECODE_TRAP, XREG_VALUE (faulting instruction word) and EXECUTE_MRET from the trap detection block.
- Runs the machine-mode trap entry and MRET return sequences: flushes the pipeline, updates mepc/mcause/mtval/mstatus, then redirects fetch to mtvec or mepc.
- Also owns the M-mode trap CSRs for Zicsr read/write.

---
 rtl/trap_handler_ctrl_if.sv | 37 +++
 rtl/trap_handler_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/trap_handler_ctrl_if.sv
// Decode-stage trap interface between the trap detector (master) and the
// trap sequencer / M-mode CSR owner (slave).
//
// Handshake semantics: DECODE_TRAP and EXECUTE_MRET are level requests with
// no ready/ack signal. The sequencer accepts a request only on the
// 0->1 transition of the level while it is idle; requests that rise while
// TRAP_BUSY=1 are dropped, not queued. PC_REDIRECT is a one-cycle strobe
// that is valid together with PC_TARGET and needs no acknowledge.
interface trap_handler_ctrl_if #(
    parameter int XLEN = 32
);
    logic            DECODE_TRAP;
    logic [XLEN-1:0] TRAP_PC;
    logic [XLEN-1:0] XREG_VALUE;
    logic            EXECUTE_MRET;
    logic            CSR_WE;
    logic [11:0]     CSR_ADDR;
    logic [XLEN-1:0] CSR_WDATA;
    logic [XLEN-1:0] CSR_RDATA;
    logic            PIPE_FLUSH;
    logic            PC_REDIRECT;
    logic [XLEN-1:0] PC_TARGET;
    logic            TRAP_BUSY;
    logic            MSTATUS_MIE;

    modport master (
        output DECODE_TRAP, TRAP_PC, XREG_VALUE, EXECUTE_MRET,
        output CSR_WE, CSR_ADDR, CSR_WDATA,
        input  CSR_RDATA, PIPE_FLUSH, PC_REDIRECT, PC_TARGET, TRAP_BUSY, MSTATUS_MIE
    );

    modport slave (
        input  DECODE_TRAP, TRAP_PC, XREG_VALUE, EXECUTE_MRET,
        input  CSR_WE, CSR_ADDR, CSR_WDATA,
        output CSR_RDATA, PIPE_FLUSH, PC_REDIRECT, PC_TARGET, TRAP_BUSY, MSTATUS_MIE
    );
endinterface

// File: rtl/trap_handler_ctrl.sv
// Machine-mode trap entry / MRET return sequencer plus the M-mode trap CSRs
// (mstatus.MIE/MPIE, mtvec, mepc, mcause, mtval).
module trap_handler_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC  = 32'h0000_0100,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RSTn,
    trap_handler_ctrl_if.slave  bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_FLUSH  = 3'd1,
        T_COMMIT = 3'd2,
        T_REDIR  = 3'd3,
        R_FLUSH  = 3'd4,
        R_COMMIT = 3'd5,
        R_REDIR  = 3'd6
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            trap_q, mret_q;
    logic            trap_edge, mret_edge;
    logic [XLEN-1:0] cap_pc, cap_val;
    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mepc, mcause, mtval;
    logic [XLEN-1:0] pc_target_q;
    logic            csr_wr;

    // A request is a rising edge of its level; trap has priority over MRET.
    assign trap_edge = bus.DECODE_TRAP & ~trap_q;
    assign mret_edge = bus.EXECUTE_MRET & ~mret_q;
    // CSR writes only land while idle so the sequencer owns the CSRs mid-sequence.
    assign csr_wr    = bus.CSR_WE && (state_q == IDLE);
    assign dbg_state = state_q;

    // State, flush counter and request edge history.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= bus.DECODE_TRAP;
            mret_q  <= bus.EXECUTE_MRET;
        end
    end

    // Next-state logic and flush down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trap_edge) begin
                    state_d = T_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (mret_edge) begin
                    state_d = R_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            T_FLUSH: begin
                if (cnt_q == 3'd0) state_d = T_COMMIT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            T_COMMIT: state_d = T_REDIR;
            T_REDIR:  state_d = IDLE;
            R_FLUSH: begin
                if (cnt_q == 3'd0) state_d = R_COMMIT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            R_COMMIT: state_d = R_REDIR;
            R_REDIR:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes and redirect target; the target holds its last value outside REDIR.
    always_comb begin
        bus.PIPE_FLUSH  = (state_q == T_FLUSH) || (state_q == R_FLUSH);
        bus.PC_REDIRECT = (state_q == T_REDIR) || (state_q == R_REDIR);
        bus.TRAP_BUSY   = (state_q != IDLE);
        bus.MSTATUS_MIE = mie;
        bus.PC_TARGET   = pc_target_q;
        if (state_q == T_REDIR)      bus.PC_TARGET = {mtvec[XLEN-1:2], 2'b00};
        else if (state_q == R_REDIR) bus.PC_TARGET = mepc;
    end

    // Hold register for PC_TARGET.
    always_ff @(posedge CLK) begin
        if (!RSTn) pc_target_q <= '0;
        else       pc_target_q <= bus.PC_TARGET;
    end

    // Capture the faulting PC and instruction word on trap acceptance.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cap_pc  <= '0;
            cap_val <= '0;
        end else if (state_q == IDLE && trap_edge) begin
            cap_pc  <= bus.TRAP_PC;
            cap_val <= bus.XREG_VALUE;
        end
    end

    // CSR file: COMMIT states update trap fields, otherwise idle-time Zicsr writes.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= RESET_MTVEC;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else if (state_q == T_COMMIT) begin
            mepc   <= {cap_pc[XLEN-1:2], 2'b00};
            mcause <= XLEN'(2);
            mtval  <= cap_val;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (state_q == R_COMMIT) begin
            mie    <= mpie;
            mpie   <= 1'b1;
        end else if (csr_wr) begin
            unique case (bus.CSR_ADDR)
                12'h300: begin
                    mie  <= bus.CSR_WDATA[3];
                    mpie <= bus.CSR_WDATA[7];
                end
                12'h305: mtvec  <= bus.CSR_WDATA;
                12'h341: mepc   <= {bus.CSR_WDATA[XLEN-1:2], 2'b00};
                12'h342: mcause <= bus.CSR_WDATA;
                12'h343: mtval  <= bus.CSR_WDATA;
                default: ;
            endcase
        end
    end

    // Combinational CSR read mux; unmapped addresses read zero.
    always_comb begin
        bus.CSR_RDATA = '0;
        unique case (bus.CSR_ADDR)
            12'h300: begin
                bus.CSR_RDATA[3] = mie;
                bus.CSR_RDATA[7] = mpie;
            end
            12'h305: bus.CSR_RDATA = mtvec;
            12'h341: bus.CSR_RDATA = mepc;
            12'h342: bus.CSR_RDATA = mcause;
            12'h343: bus.CSR_RDATA = mtval;
            default: bus.CSR_RDATA = '0;
        endcase
    end

endmodule
